// File: rtl/uc_pkg.sv
// Shared definitions for the DAPA2014 control unit.
// States, opcode field codes and ALU pass-through selects.
package uc_pkg;

    typedef enum logic [3:0] {
        INIT,
        FETCH,
        DECODE,
        E1,
        E2,
        E3,
        E4,
        E5,
        HALT
    } state_t;

    localparam logic [1:0] CL_SYS  = 2'b00;
    localparam logic [1:0] CL_ALUR = 2'b01;
    localparam logic [1:0] CL_ALUI = 2'b10;
    localparam logic [1:0] CL_BR   = 2'b11;

    localparam logic [2:0] FN_NOP  = 3'b000;
    localparam logic [2:0] FN_LD   = 3'b001;
    localparam logic [2:0] FN_ST   = 3'b010;
    localparam logic [2:0] FN_PUSH = 3'b011;
    localparam logic [2:0] FN_POP  = 3'b100;
    localparam logic [2:0] FN_HALT = 3'b111;

    localparam logic [2:0] CC_Z   = 3'b000;
    localparam logic [2:0] CC_NZ  = 3'b001;
    localparam logic [2:0] CC_C   = 3'b010;
    localparam logic [2:0] CC_NC  = 3'b011;
    localparam logic [2:0] CC_N   = 3'b100;
    localparam logic [2:0] CC_V   = 3'b101;
    localparam logic [2:0] CC_AL  = 3'b110;
    localparam logic [2:0] CC_HLT = 3'b111;

    localparam logic [3:0] OP_PASSA = 4'hE;
    localparam logic [3:0] OP_PASSB = 4'hF;

endpackage

// File: rtl/uc_cond.sv
// Branch condition evaluator.
// Compares a condition code against the status flags.
module uc_cond
    import uc_pkg::*;
(
    input  logic [2:0] cc,
    input  logic       v,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    output logic       take
);

    // Select the flag test named by the condition code
    always_comb begin
        take = 1'b0;
        case (cc)
            CC_Z:    take = z;
            CC_NZ:   take = ~z;
            CC_C:    take = c;
            CC_NC:   take = ~c;
            CC_N:    take = n;
            CC_V:    take = v;
            CC_AL:   take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/unidad_control.sv
// Multi-cycle Moore control unit for the DAPA2014 processor.
// Build option: define UC_STACK_EN to enable PUSH/POP.
module unidad_control
    import uc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir15_8,
    input  logic       v,
    input  logic       n,
    input  logic       z,
    input  logic       c,
    output logic       wreg,
    output logic       ws,
    output logic       inm,
    output logic       wac,
    output logic       rac,
    output logic       isp,
    output logic       dsp,
    output logic       csp,
    output logic       rsp,
    output logic       ipc,
    output logic       wpc,
    output logic       rpc,
    output logic       wir,
    output logic       i_o_,
    output logic       wmdr,
    output logic       wmar,
    output logic       wmem,
    output logic       rmem,
    output logic       cpc,
    output logic [3:0] op,
    output logic       halted
);

    state_t     state;
    state_t     nstate;
    logic [1:0] cls_q;
    logic [2:0] fn_q;
    logic       take;
    logic [1:0] cls_d;
    logic [2:0] fn_d;
    logic       unused_reg;

    assign cls_d      = ir15_8[7:6];
    assign fn_d       = ir15_8[5:3];
    assign unused_reg = ^ir15_8[2:0];

    uc_cond u_cond (
        .cc   (fn_d),
        .v    (v),
        .n    (n),
        .z    (z),
        .c    (c),
        .take (take)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT;
        else       state <= nstate;
    end

    // Capture the opcode fields once, in DECODE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_q <= CL_SYS;
            fn_q  <= FN_NOP;
        end else if (state == DECODE) begin
            cls_q <= cls_d;
            fn_q  <= fn_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        nstate = state;
        case (state)
            INIT:   nstate = FETCH;
            FETCH:  nstate = DECODE;
            DECODE: begin
                nstate = FETCH;
                case (cls_d)
                    CL_SYS: begin
                        case (fn_d)
                            FN_LD,
                            FN_ST:   nstate = E1;
`ifdef UC_STACK_EN
                            FN_PUSH,
                            FN_POP:  nstate = E1;
`endif
                            FN_HALT: nstate = HALT;
                            default: nstate = FETCH;
                        endcase
                    end
                    CL_BR: begin
                        if (fn_d == CC_HLT) nstate = HALT;
                        else if (take)      nstate = E1;
                    end
                    default: nstate = E1;
                endcase
            end
            E1: nstate = E2;
            E2: begin
                if (cls_q == CL_SYS) nstate = E3;
                else                 nstate = FETCH;
            end
            E3: nstate = E4;
            E4: begin
                if (fn_q == FN_ST) nstate = E5;
                else               nstate = FETCH;
            end
            E5:      nstate = FETCH;
            HALT:    nstate = HALT;
            default: nstate = INIT;
        endcase
    end

    // Strobe decode from state and latched opcode; reset forces all low
    always_comb begin
        wreg   = 1'b0;
        ws     = 1'b0;
        inm    = 1'b0;
        wac    = 1'b0;
        rac    = 1'b0;
        isp    = 1'b0;
        dsp    = 1'b0;
        csp    = 1'b0;
        rsp    = 1'b0;
        ipc    = 1'b0;
        wpc    = 1'b0;
        rpc    = 1'b0;
        wir    = 1'b0;
        i_o_   = 1'b0;
        wmdr   = 1'b0;
        wmar   = 1'b0;
        wmem   = 1'b0;
        rmem   = 1'b0;
        cpc    = 1'b0;
        op     = 4'h0;
        halted = 1'b0;
        if (!reset) begin
            case (state)
                INIT: begin
                    cpc = 1'b1;
                    csp = 1'b1;
                end
                FETCH:  wir = 1'b1;
                DECODE: ipc = 1'b1;
                E1: begin
                    case (cls_q)
                        CL_ALUR, CL_ALUI: begin
                            op  = {1'b0, fn_q};
                            inm = (cls_q == CL_ALUI);
                            ws  = 1'b1;
                            wac = 1'b1;
                        end
                        CL_BR: begin
                            op  = OP_PASSB;
                            inm = 1'b1;
                            wac = 1'b1;
                        end
                        default: begin
                            case (fn_q)
                                FN_LD, FN_ST: begin
                                    op  = OP_PASSB;
                                    inm = 1'b1;
                                    wac = 1'b1;
                                end
`ifdef UC_STACK_EN
                                FN_PUSH: begin
                                    rsp  = 1'b1;
                                    wmar = 1'b1;
                                end
                                FN_POP: isp = 1'b1;
`endif
                                default: ;
                            endcase
                        end
                    endcase
                end
                E2: begin
                    case (cls_q)
                        CL_ALUR, CL_ALUI: begin
                            rac  = 1'b1;
                            wreg = 1'b1;
                        end
                        CL_BR: begin
                            rac = 1'b1;
                            wpc = 1'b1;
                        end
                        default: begin
                            case (fn_q)
                                FN_LD, FN_ST: begin
                                    rac  = 1'b1;
                                    wmar = 1'b1;
                                end
`ifdef UC_STACK_EN
                                FN_PUSH: begin
                                    op  = OP_PASSA;
                                    wac = 1'b1;
                                end
                                FN_POP: begin
                                    rsp  = 1'b1;
                                    wmar = 1'b1;
                                end
`endif
                                default: ;
                            endcase
                        end
                    endcase
                end
                E3: begin
                    case (fn_q)
                        FN_ST: begin
                            op  = OP_PASSA;
                            wac = 1'b1;
                        end
`ifdef UC_STACK_EN
                        FN_PUSH: begin
                            rac  = 1'b1;
                            wmdr = 1'b1;
                        end
`endif
                        default: begin
                            rmem = 1'b1;
                            i_o_ = 1'b1;
                            wmdr = 1'b1;
                        end
                    endcase
                end
                E4: begin
                    case (fn_q)
                        FN_ST: begin
                            rac  = 1'b1;
                            wmdr = 1'b1;
                        end
`ifdef UC_STACK_EN
                        FN_PUSH: begin
                            wmem = 1'b1;
                            dsp  = 1'b1;
                        end
`endif
                        default: begin
                            i_o_ = 1'b1;
                            wreg = 1'b1;
                        end
                    endcase
                end
                E5:      wmem   = 1'b1;
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_control.sv
// Self-checking bench for unidad_control.
// Expected strobe traces come from per-instruction tables.
module tb_unidad_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ir15_8 = 8'h00;
    logic       v = 1'b0, n = 1'b0, z = 1'b0, c = 1'b0;
    logic wreg, ws, inm, wac, rac, isp, dsp, csp, rsp, ipc;
    logic wpc, rpc, wir, i_o_, wmdr, wmar, wmem, rmem, cpc;
    logic [3:0] op;
    logic       halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unidad_control dut (
        .clk(clk), .reset(reset), .ir15_8(ir15_8),
        .v(v), .n(n), .z(z), .c(c),
        .wreg(wreg), .ws(ws), .inm(inm), .wac(wac), .rac(rac),
        .isp(isp), .dsp(dsp), .csp(csp), .rsp(rsp), .ipc(ipc),
        .wpc(wpc), .rpc(rpc), .wir(wir), .i_o_(i_o_), .wmdr(wmdr),
        .wmar(wmar), .wmem(wmem), .rmem(rmem), .cpc(cpc),
        .op(op), .halted(halted)
    );

    localparam logic [23:0] CPC  = 24'd1 << 0;
    localparam logic [23:0] RMEM = 24'd1 << 1;
    localparam logic [23:0] WMEM = 24'd1 << 2;
    localparam logic [23:0] WMAR = 24'd1 << 3;
    localparam logic [23:0] WMDR = 24'd1 << 4;
    localparam logic [23:0] IO   = 24'd1 << 5;
    localparam logic [23:0] WIR  = 24'd1 << 6;
    localparam logic [23:0] WPC  = 24'd1 << 8;
    localparam logic [23:0] IPC  = 24'd1 << 9;
    localparam logic [23:0] RSP  = 24'd1 << 10;
    localparam logic [23:0] CSP  = 24'd1 << 11;
    localparam logic [23:0] DSP  = 24'd1 << 12;
    localparam logic [23:0] ISP  = 24'd1 << 13;
    localparam logic [23:0] RAC  = 24'd1 << 14;
    localparam logic [23:0] WAC  = 24'd1 << 15;
    localparam logic [23:0] INM  = 24'd1 << 16;
    localparam logic [23:0] WS   = 24'd1 << 17;
    localparam logic [23:0] WREG = 24'd1 << 18;
    localparam logic [23:0] HLT  = 24'd1 << 19;
    localparam logic [23:0] PSA  = 24'hE00000;
    localparam logic [23:0] PSB  = 24'hF00000;

    logic [23:0] obs;
    assign obs = {op, halted, wreg, ws, inm, wac, rac, isp, dsp, csp,
                  rsp, ipc, wpc, rpc, wir, i_o_, wmdr, wmar, wmem,
                  rmem, cpc};

`ifdef UC_STACK_EN
    localparam bit STACK = 1'b1;
`else
    localparam bit STACK = 1'b0;
`endif

    task automatic chk(input string tag, input logic [23:0] exp);
        int drv;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
        drv = int'(rac) + int'(rsp) + int'(rpc) + int'(i_o_ & ~wmdr);
        checks++;
        assert ((drv <= 1 && !(wmem && rmem)) === 1'b1) else begin
            errors++;
            $display("FAIL %s_bus observed=%0d expected<=1 wm=%b rm=%b",
                     tag, drv, wmem, rmem);
            $error("check %s_bus", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit taken(input logic [2:0] f,
                                 input logic [3:0] fl);
        // fl = {v, n, z, c}
        case (f)
            3'd0:    return fl[1];
            3'd1:    return !fl[1];
            3'd2:    return fl[0];
            3'd3:    return !fl[0];
            3'd4:    return fl[2];
            3'd5:    return fl[3];
            3'd6:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Build the per-cycle strobe trace of one instruction
    function automatic void model(input logic [7:0] opc,
                                  input logic [3:0] fl,
                                  output logic [23:0] q[$]);
        logic [1:0] cl;
        logic [2:0] f;
        logic [23:0] opf;
        cl  = opc[7:6];
        f   = opc[5:3];
        opf = {1'b0, f, 20'd0};
        q = {};
        q.push_back(WIR);
        q.push_back(IPC);
        if (cl == 2'b01 || cl == 2'b10) begin
            q.push_back(opf | WS | WAC | (cl == 2'b10 ? INM : 24'd0));
            q.push_back(RAC | WREG);
        end else if (cl == 2'b11) begin
            if (f == 3'd7) begin
                for (int i = 0; i < 20; i++) q.push_back(HLT);
            end else if (taken(f, fl)) begin
                q.push_back(PSB | INM | WAC);
                q.push_back(RAC | WPC);
            end
        end else begin
            if (f == 3'd1 || f == 3'd2) begin
                q.push_back(PSB | INM | WAC);
                q.push_back(RAC | WMAR);
            end
            if (f == 3'd1) begin
                q.push_back(RMEM | IO | WMDR);
                q.push_back(IO | WREG);
            end else if (f == 3'd2) begin
                q.push_back(PSA | WAC);
                q.push_back(RAC | WMDR);
                q.push_back(WMEM);
            end else if (f == 3'd3 && STACK) begin
                q.push_back(RSP | WMAR);
                q.push_back(PSA | WAC);
                q.push_back(RAC | WMDR);
                q.push_back(WMEM | DSP);
            end else if (f == 3'd4 && STACK) begin
                q.push_back(ISP);
                q.push_back(RSP | WMAR);
                q.push_back(RMEM | IO | WMDR);
                q.push_back(IO | WREG);
            end else if (f == 3'd7) begin
                for (int i = 0; i < 20; i++) q.push_back(HLT);
            end
        end
    endfunction

    // Run one instruction starting in FETCH; stop early if stop_at > 0
    task automatic run(input string tag, input logic [7:0] opc,
                       input logic [3:0] fl, input int stop_at);
        logic [23:0] q[$];
        ir15_8 = opc;
        {v, n, z, c} = fl;
        model(opc, fl, q);
        for (int i = 0; i < q.size(); i++) begin
            chk($sformatf("%s_c%0d", tag, i), q[i]);
            if (stop_at > 0 && i == stop_at - 1) return;
            step();
        end
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1 chk({tag, "_async"}, 24'd0);
        step();
        chk({tag, "_held"}, 24'd0);
        reset = 1'b0;
        #1 chk({tag, "_init"}, CPC | CSP);
        step();
    endtask

    initial begin
        logic [7:0] r;
        logic [3:0] fl;
        step();
        step();
        chk("rst_hold", 24'd0);
        reset = 1'b0;
        #1 chk("init", CPC | CSP);
        step();

        run("alu_r", 8'b01_000_010, 4'b0000, 0);
        run("alu_i", 8'b10_101_001, 4'b0000, 0);
        run("br_nt", 8'b11_000_000, 4'b0000, 0);
        run("br_t",  8'b11_000_000, 4'b0010, 0);
        run("br_al", 8'b11_110_000, 4'b0000, 0);
        run("ld",    8'b00_001_011, 4'b0000, 0);
        run("st",    8'b00_010_011, 4'b1111, 0);
        run("nop",   8'b00_000_000, 4'b0000, 0);
        run("rsv",   8'b00_110_000, 4'b0000, 0);
        run("push",  8'b00_011_001, 4'b0000, 0);
        run("pop",   8'b00_100_001, 4'b0000, 0);

        run("st_rst", 8'b00_010_100, 4'b0000, 6);
        do_reset("rst_st");
        chk("rst_fetch", WIR);

        for (int k = 0; k < 300; k++) begin
            do begin
                r = 8'($urandom);
            end while ((r[7:6] == 2'b00 || r[7:6] == 2'b11) &&
                       r[5:3] == 3'b111);
            fl = 4'($urandom);
            run($sformatf("rnd%0d", k), r, fl, 0);
        end

        run("halt", 8'b00_111_000, 4'b0000, 0);
        do_reset("rst_h");
        run("alu_ah", 8'b01_011_000, 4'b0000, 0);
        run("bhalt", 8'b11_111_000, 4'b0000, 0);
        do_reset("rst_b");
        chk("fetch_b", WIR);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidad_control.md
# unidad_control

Multi-cycle control unit for the DAPA2014 8-bit processor. It reads the opcode byte `ir15_8` and the status flags `v n z c` from `unidad_datos`. From these it generates every datapath strobe, sequencing fetch, decode and a per-instruction execute micro-sequence. The block is a single Moore FSM, and all outputs are decoded from state and the latched opcode.

## Interface
Parameters: none.

Ports:
- `clk` in 1: system clock; all state changes occur on its rising edge.
- `reset` in 1: asynchronous, active-high; forces state INIT.
- `ir15_8` in 8: opcode byte of the current instruction, latched by the datapath IR.
- `v n z c` in 1 each: status register outputs.
- `wreg ws inm wac rac isp dsp csp rsp ipc wpc rpc wir i_o_ wmdr wmar wmem rmem cpc` out 1 each: datapath strobes.
- `op` out 4: ALU operation select.
- `halted` out 1: high while the FSM is in state HALT.

## Operation
Opcode decode:
- `ir[15:14]` is the class field.
- `ir[13:11]` is the function field `f`.
- `ir[10:8]` is the register field, which the datapath consumes directly.

Classes:
- 00 memory/system:
  - f=000 NOP
  - f=001 LD r ← mem[imm]
  - f=010 ST mem[imm] ← r
  - f=011 PUSH r
  - f=100 POP r
  - f=101 and f=110 reserved, executed as NOP
  - f=111 HALT
- 01 ALU register form: `op={0,f}`, `inm=0`.
- 10 ALU immediate form: `op={0,f}`, `inm=1`.
- 11 conditional branch to imm. Condition by f: 000 Z, 001 !Z, 010 C, 011 !C, 100 N, 101 V, 110 always, 111 HALT.

ALU pass-through ops:
- `OP_PASSA`=4'hE: result = register `ir[10:8]`.
- `OP_PASSB`=4'hF: result = B input (the immediate when `inm=1`).

MDR direction contract:
- `i_o_=1`: MDR latches `ram_data` on `wmdr`. When `wmdr=0`, MDR drives the internal bus.
- `i_o_=0`: MDR latches the internal bus on `wmdr` and drives `ram_data`.

Micro-sequences. Each item is one cycle with the strobes asserted in that cycle. Unlisted outputs are 0.
- INIT: `cpc=1`, `csp=1` → FETCH.
- FETCH: `wir=1` → DECODE.
- DECODE: `ipc=1`. Dispatches to E1, returns to FETCH for NOP/reserved or a false branch, or goes to HALT.
- ALU:
  - E1: `op`, `inm` per class, `ws=1`, `wac=1`.
  - E2: `rac=1`, `wreg=1`.
- LD:
  - E1: `OP_PASSB`, `inm=1`, `wac=1`.
  - E2: `rac=1`, `wmar=1`.
  - E3: `rmem=1`, `i_o_=1`, `wmdr=1`.
  - E4: `i_o_=1`, `wreg=1`.
- ST:
  - E1 and E2 as LD.
  - E3: `OP_PASSA`, `wac=1`.
  - E4: `rac=1`, `wmdr=1`.
  - E5: `wmem=1`.
- PUSH:
  - E1: `rsp=1`, `wmar=1`.
  - E2: `OP_PASSA`, `wac=1`.
  - E3: `rac=1`, `wmdr=1`.
  - E4: `wmem=1`, `dsp=1`.
- POP:
  - E1: `isp=1`.
  - E2: `rsp=1`, `wmar=1`.
  - E3: `rmem=1`, `i_o_=1`, `wmdr=1`.
  - E4: `i_o_=1`, `wreg=1`.
- Branch taken:
  - E1: `OP_PASSB`, `inm=1`, `wac=1`.
  - E2: `rac=1`, `wpc=1`.
- HALT: all strobes 0, `halted=1`. The FSM stays in HALT until reset.

Rules:
- `ws=1` only in ALU E1. Internal moves never alter flags.
- The branch condition is evaluated in DECODE on the current SR.
- At most one bus driver per cycle (`rac`, `rsp`, `rpc`, MDR). `wmem` and `rmem` are never asserted together.

## Timing
- Reset values:
  - State INIT.
  - `op`=0 and all 1-bit outputs 0, including `cpc`, `csp` and `halted`, while `reset` is high.
  - INIT strobes `cpc`/`csp` appear in the first cycle after reset deasserts.
- Total cycles per instruction, FETCH included:
  - NOP: 2
  - not-taken branch: 2
  - ALU: 4
  - taken branch: 4
  - LD: 6
  - POP: 6
  - PUSH: 6
  - ST: 7
- `ir15_8` is valid from the cycle after FETCH. The controller registers the decoded class and f in DECODE; later states do not re-read `ir15_8`.
- Reset mid-instruction: the FSM returns to INIT asynchronously, all strobes drop immediately, and a pending `wmem` is suppressed.
- After decode, PC already points to the next instruction. A taken branch overwrites it in E2.

## Configuration
- `UC_STACK_EN` defined: PUSH/POP execute as specified.
- `UC_STACK_EN` undefined:
  - f=011 and f=100 decode as NOP (2 cycles).
  - `isp`, `dsp` and `rsp` are tied to 0.
  - `csp` is still pulsed in INIT.

## Structure
- Package `uc_pkg` holds:
  - the state enumeration INIT, FETCH, DECODE, E1–E5, HALT;
  - class codes, function codes and condition codes;
  - `OP_PASSA` and `OP_PASSB`.
- Sub-module `uc_cond`: combinational evaluation of the condition code against `v n z c`, returning `take`. It is instantiated once.

## Test plan
- Reset asserted mid-ST E4, then released → all strobes 0 during reset; next cycle `cpc=csp=1`; then FETCH `wir=1`.
- `ir15_8`=8'b01_000_010 (ALU op 0, reg 2) → DECODE `ipc`; E1 `op`=0, `ws=wac=1`, `inm=0`; E2 `rac=wreg=1`; back to FETCH. Total 4 cycles.
- Branch f=000 with z=0 → FETCH directly after DECODE. Same opcode with z=1 → E1 `op`=4'hF, `inm=wac=1`; E2 `wpc=rac=1`.
- LD then ST → strobe trace exactly per the micro-sequences. `wmem` occurs only in ST E5, `rmem` only in LD E3. Never two bus drivers in one cycle.
- PUSH then POP with `UC_STACK_EN` defined → `dsp` in PUSH E4, `isp` in POP E1. With the macro undefined, both take 2 cycles and `isp/dsp/rsp` stay 0.
- `ir15_8`=8'b00_111_000 → HALT; `halted=1` and all strobes 0 for 20 cycles; reset → INIT.
